// File: rtl/led_panel_shifter.sv
// Scan/shift timing generator for a 1/16-scan HUB75-style LED panel.
// Produces shift clock, latch, active-low OE, row address and the column index for the pixel source.
module led_panel_shifter #(
   parameter int COLS      = 64,
   parameter int ON_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       led_clk,
   output logic       led_latch,
   output logic       led_oe,
   output logic [3:0] dmux,
   output logic [5:0] x
);

   localparam int DW = (ON_CYCLES > 0) ? $clog2(ON_CYCLES + 1) : 1;
   localparam logic [5:0]    COL_LAST  = 6'(COLS - 1);
   localparam logic [DW-1:0] DISP_LAST = DW'((ON_CYCLES > 0) ? ON_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_ROW,
      S_DISP
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    col_q, col_d;
   logic          phase_q, phase_d;
   logic [DW-1:0] disp_q, disp_d;
   logic [3:0]    dmux_q, dmux_d;
   logic          primed_q, primed_d;
   logic          led_clk_q, led_clk_d;
   logic          led_latch_q, led_latch_d;
   logic          led_oe_q, led_oe_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_SHIFT;
         col_q       <= '0;
         phase_q     <= 1'b0;
         disp_q      <= '0;
         dmux_q      <= 4'd15;
         primed_q    <= 1'b0;
         led_clk_q   <= 1'b0;
         led_latch_q <= 1'b0;
         led_oe_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         phase_q     <= phase_d;
         disp_q      <= disp_d;
         dmux_q      <= dmux_d;
         primed_q    <= primed_d;
         led_clk_q   <= led_clk_d;
         led_latch_q <= led_latch_d;
         led_oe_q    <= led_oe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      phase_d  = phase_q;
      disp_d   = disp_q;
      dmux_d   = dmux_q;
      primed_d = primed_q;
      case (state_q)
         S_SHIFT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (col_q == COL_LAST) state_d = S_BLANK;
               else                   col_d   = col_q + 6'd1;
            end
         end
         S_BLANK: state_d = S_LATCH;
         S_LATCH: state_d = S_ROW;
         S_ROW: begin
            // Row address moves only here, while the panel is blanked.
            dmux_d   = 4'(dmux_q + 4'd1);
            primed_d = 1'b1;
            col_d    = '0;
            phase_d  = 1'b0;
            if (ON_CYCLES == 0) begin
               state_d = S_SHIFT;
            end else begin
               state_d = S_DISP;
               disp_d  = DISP_LAST;
            end
         end
         S_DISP: begin
            if (disp_q == '0) state_d = S_SHIFT;
            else              disp_d  = disp_q - DW'(1);
         end
         default: state_d = S_SHIFT;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered alongside it.
   always_comb begin
      led_clk_d   = (state_d == S_SHIFT) && phase_d;
      led_latch_d = (state_d == S_LATCH);
      case (state_d)
         S_SHIFT: led_oe_d = ~primed_d;
         S_DISP:  led_oe_d = 1'b0;
         default: led_oe_d = 1'b1;
      endcase
   end

   assign led_clk   = led_clk_q;
   assign led_latch = led_latch_q;
   assign led_oe    = led_oe_q;
   assign dmux      = dmux_q;
   assign x         = col_q;

endmodule

// File: tb/tb_led_panel_shifter.sv
// Bench for led_panel_shifter: default and ON_CYCLES=0 instances against a cycle-index reference model.
module tb_led_panel_shifter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lc  [2];
   logic       ll  [2];
   logic       oe  [2];
   logic [3:0] dm  [2];
   logic [5:0] xx  [2];

   int n_chk  = 0;
   int n_fail = 0;
   int cur_t  = 0;
   int last_latch [2];
   int rises      [2];
   logic prev_clk [2];

   always #5 clk = ~clk;

   led_panel_shifter #(.COLS(64), .ON_CYCLES(16)) u_def (
      .clk(clk), .rst_n(rst_n), .led_clk(lc[0]), .led_latch(ll[0]),
      .led_oe(oe[0]), .dmux(dm[0]), .x(xx[0]));

   led_panel_shifter #(.COLS(64), .ON_CYCLES(0)) u_on0 (
      .clk(clk), .rst_n(rst_n), .led_clk(lc[1]), .led_latch(ll[1]),
      .led_oe(oe[1]), .dmux(dm[1]), .x(xx[1]));

   typedef struct {
      logic       clk;
      logic       latch;
      logic       oe;
      logic [3:0] dmux;
      logic [5:0] x;
      logic       x_care;
   } exp_t;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got %0d expected %0d", tag, cur_t, act, exp);
      end
   endtask

   // Row layout: 2*COLS shift cycles, blank, latch, row-advance, then ON cycles lit.
   function automatic exp_t model(input int on, input int t);
      exp_t e;
      int period = 2 * 64 + 3 + on;
      int r      = t / period;
      int p      = t % period;
      int rows_done = r + ((p > 130) ? 1 : 0);
      e.dmux   = 4'((15 + rows_done) % 16);
      e.latch  = (p == 129);
      e.x_care = 1'b1;
      if (p < 128) begin
         e.clk = (p % 2 == 1);
         e.x   = 6'(p / 2);
         e.oe  = (rows_done == 0);
      end else if (p <= 129) begin
         e.clk = 1'b0;
         e.x   = 6'd63;
         e.oe  = 1'b1;
      end else if (p == 130) begin
         e.clk = 1'b0;
         e.x   = 6'd0;
         e.x_care = 1'b0;
         e.oe  = 1'b1;
      end else begin
         e.clk = 1'b0;
         e.x   = 6'd0;
         e.oe  = 1'b0;
      end
      return e;
   endfunction

   task automatic check_reset_vals();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst%0d_clk", k),   int'(lc[k]), 0);
         chk($sformatf("rst%0d_latch", k), int'(ll[k]), 0);
         chk($sformatf("rst%0d_oe", k),    int'(oe[k]), 1);
         chk($sformatf("rst%0d_dmux", k),  int'(dm[k]), 15);
         chk($sformatf("rst%0d_x", k),     int'(xx[k]), 0);
      end
   endtask

   task automatic restart_trackers();
      for (int k = 0; k < 2; k++) begin
         last_latch[k] = -1;
         rises[k]      = 0;
         prev_clk[k]   = 1'b0;
      end
   endtask

   task automatic check_cycle(input int t);
      exp_t e;
      int on;
      for (int k = 0; k < 2; k++) begin
         on = (k == 0) ? 16 : 0;
         e  = model(on, t);
         chk($sformatf("d%0d_clk", k),   int'(lc[k]), int'(e.clk));
         chk($sformatf("d%0d_latch", k), int'(ll[k]), int'(e.latch));
         chk($sformatf("d%0d_oe", k),    int'(oe[k]), int'(e.oe));
         chk($sformatf("d%0d_dmux", k),  int'(dm[k]), int'(e.dmux));
         if (e.x_care) chk($sformatf("d%0d_x", k), int'(xx[k]), int'(e.x));
         if (last_latch[k] < 0 && lc[k] && !prev_clk[k]) rises[k]++;
         prev_clk[k] = lc[k];
         if (ll[k]) begin
            if (last_latch[k] < 0) begin
               chk($sformatf("d%0d_first_latch_t", k), t, 129);
               chk($sformatf("d%0d_clk_rises", k), rises[k], 64);
            end else begin
               chk($sformatf("d%0d_row_period", k), t - last_latch[k], 2 * 64 + 3 + on);
            end
            last_latch[k] = t;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         check_cycle(cur_t);
         @(posedge clk);
         @(negedge clk);
         cur_t++;
      end
   endtask

   initial begin
      int pulse_t;
      rst_n = 1'b0;
      restart_trackers();
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         check_reset_vals();
      end
      // Randomized pre-release idle keeps reset robust to hold length.
      repeat ($urandom_range(3, 0)) begin
         @(posedge clk);
         @(negedge clk);
         check_reset_vals();
      end
      rst_n = 1'b1;
      cur_t = 0;
      // Third row of the default instance, column 30.
      pulse_t = 2 * 147 + 60;
      run(pulse_t);
      check_cycle(cur_t);
      chk("x_at_pulse", int'(xx[0]), 30);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      cur_t = 0;
      restart_trackers();
      run(13000 + int'($urandom_range(200, 0)));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
